program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader upstream of the core's instruction fetch. Receives a program as a UART byte stream, packs little-endian bytes into 32-bit words, and writes them sequentially into instruction memory from word address 0. Holds the core in reset until the program is fully written, then releases it and sends a one-byte acknowledge back over the UART transmitter.

## Interface
Parameters:
- ADDR_W, 12: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- TIMEOUT_CYC, 1000000: idle cycles allowed between bytes of one transfer before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word to write.
- core_rst  out  1  reset to the core; high until load completes.
- tx_valid  out  1  acknowledge byte valid.
- tx_data  out  8  acknowledge byte.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- busy  out  1  transfer in progress (header or payload).
- err  out  1  sticky error flag.

## Operation
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, tx_valid=0, tx_data=0, busy=0, err=0; state IDLE.
- Stream format: 4-byte header N (word count, little-endian), then 4·N payload bytes, little-endian per word.
- States: IDLE → HDR (first byte received) → LOAD (4th header byte, N≥1) → [CSUM] → ACK → DONE; any state except DONE → ERROR on fault.
- IDLE: first rx_valid byte becomes header byte 0; busy=1.
- HDR: after the 4th byte, N==0 → ACK (or CSUM); N>DEPTH → ERROR; otherwise LOAD with word counter=0.
- LOAD: byte counter 0..3 shifts bytes into bits [7:0],[15:8],[23:16],[31:24]. On the 4th byte, write word at imem_addr=word counter; increment word counter; after word N−1 → next state.
- ACK: tx_valid=1, tx_data=0x06 held until tx_ready; then DONE.
- DONE: core_rst=0, busy=0; further rx bytes ignored. Only rst reloads.
- ERROR: err=1, core_rst=1; sends 0x15 once (same handshake), then remains in ERROR until rst.
- Timeout: in HDR/LOAD/CSUM, a counter reset on each rx_valid; reaching TIMEOUT_CYC → ERROR.
- rx_valid in ACK/ERROR-send is dropped.
- rst mid-transfer: all state cleared, partially written memory is left as is, core_rst=1.

## Timing
- imem_we is a one-cycle pulse, registered: asserted the cycle after the clock edge that accepted the word's 4th byte; imem_addr/imem_wdata are valid in that same cycle.
- Back-to-back rx_valid on consecutive cycles is supported; throughput is one byte per cycle.
- tx_valid rises the cycle after entering ACK/ERROR; falls the cycle after the handshake.
- core_rst falls the cycle after the 0x06 handshake completes; it never falls with err=1.
- Timeout fires exactly TIMEOUT_CYC cycles after the last accepted byte.

## Configuration
- LOADER_CHECKSUM_EN defined: one extra byte follows the payload (or the header if N=0); state CSUM compares it to the XOR of all payload bytes (0x00 for N=0). Match → ACK; mismatch → ERROR.
- Undefined: no CSUM state, no trailing byte; the last word goes directly to ACK.

## Structure
- loader_pkg: state enum (IDLE, HDR, LOAD, CSUM, ACK, DONE, ERROR), ACK_BYTE=8'h06, NAK_BYTE=8'h15.
- Sub-module word_packer: byte counter plus 32-bit shift register. Emits word_valid and the packed word; cleared by rst or abort.

## Test plan
- Header N=2, payload 78 56 34 12 EF BE AD DE → writes 0x12345678 to addr 0 and 0xDEADBEEF to addr 1; then tx 0x06, then core_rst=0.
- N=0 (00 00 00 00) → no imem_we; 0x06 sent; core_rst=0.
- Header N=DEPTH+1 → err=1, 0x15 sent, core_rst stays 1, and later bytes produce no writes.
- Stall after 5 bytes of an N=1 transfer for TIMEOUT_CYC cycles → err=1, 0x15 sent. With tx_ready held low for 10 cycles, tx_valid/tx_data stay stable.
- With LOADER_CHECKSUM_EN, N=1, payload 01 02 04 08: checksum 0x0F → ACK; checksum 0x0E → ERROR with core_rst=1.
- rst asserted mid-LOAD, then a fresh N=1 stream → word written at addr 0 and normal completion.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and UART acknowledge bytes for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, ACK, DONE, ERROR} state_t;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs a little-endian byte stream into 32-bit words, one word per 4 bytes.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    always_comb begin
        cnt_d      = clr ? 2'd0 : in_valid ? cnt_q + 2'd1 : cnt_q;
        sr_d       = clr ? 24'd0 : in_valid ? {in_data, sr_q[23:8]} : sr_q;
        word_valid = in_valid && cnt_q == 2'd3;
        word       = {in_data, sr_q};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: UART boot loader writing a length-prefixed program into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err
);
    localparam int          CW    = ADDR_W + 1;
    localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CSUM;
`else
    localparam state_t AFTER_LOAD = ACK;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d, n_q, n_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              imem_we_q, imem_we_d, tx_valid_q, tx_valid_d, sent_q, sent_d;
    logic              core_rst_q, core_rst_d, busy_q, busy_d, err_q, err_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d, word;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              accept, word_valid;

    assign accept = rx_valid && (state_q inside {IDLE, HDR, LOAD});

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q == ERROR),
        .in_valid   (accept),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    always_comb csum_d = (state_q == LOAD && rx_valid) ? csum_q ^ rx_data : csum_q;
    always_ff @(posedge clk) csum_q <= rst ? 8'd0 : csum_d;
`endif

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        n_d          = n_q;
        tmo_d        = '0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        sent_d       = sent_q;
        case (state_q)
            IDLE: if (rx_valid) state_d = HDR;
            HDR: if (word_valid) begin
                state_d    = word == '0 ? AFTER_LOAD : {1'b0, word} > DEPTH ? ERROR : LOAD;
                word_cnt_d = '0;
                n_d        = word[CW-1:0];
            end
            LOAD: if (word_valid) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                imem_wdata_d = word;
                word_cnt_d   = word_cnt_q + CW'(1);
                if (word_cnt_q == n_q - CW'(1)) state_d = AFTER_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (rx_valid) state_d = rx_data == csum_q ? ACK : ERROR;
`endif
            ACK: if (!tx_valid_q) begin
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_BYTE;
            end else if (tx_ready) begin
                tx_valid_d = 1'b0;
                state_d    = DONE;
            end
            // the NAK goes out exactly once; sent_q keeps ERROR quiet afterwards
            ERROR: if (!sent_q && !tx_valid_q) begin
                tx_valid_d = 1'b1;
                tx_data_d  = NAK_BYTE;
            end else if (tx_valid_q && tx_ready) begin
                tx_valid_d = 1'b0;
                sent_d     = 1'b1;
            end
            default: ;
        endcase
        if (state_q inside {HDR, LOAD, CSUM}) begin
            tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
            if (!rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = ERROR;
        end
        core_rst_d = state_d != DONE;
        busy_d     = state_d inside {HDR, LOAD, CSUM, ACK};
        err_d      = err_q || state_d == ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            n_q          <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            sent_q       <= 1'b0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            n_q          <= n_d;
            tmo_q        <= tmo_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            sent_q       <= sent_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign err        = err_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected writes and UART replies are queued as stimulus is built.
module tb_program_loader;
    localparam int AW  = 4;
    localparam int TMO = 40;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          imem_we, core_rst, tx_valid, busy, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [7:0]    tx_data;

    int            n_checks = 0, n_fail = 0;
    logic [7:0]    stream[$];
    logic [AW+31:0] exp_w[$];
    logic [7:0]    exp_tx[$];
    logic [7:0]    csum;

    program_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            n_checks++;
            if (exp_w.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0h data=%h", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_w.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL imem_write got addr=%0h data=%h expected addr=%0h data=%h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        if (tx_valid && tx_ready) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tx byte=%h", tx_data);
            end else begin
                logic [7:0] t;
                t = exp_tx.pop_front();
                if (tx_data !== t) begin
                    n_fail++;
                    $display("FAIL tx_byte got %h expected %h", tx_data, t);
                end
            end
        end
        if (!rst && !core_rst && err) begin
            n_checks++;
            n_fail++;
            $display("FAIL core_rst_with_err core_rst=%b err=%b expected core_rst=1", core_rst, err);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        csum = 8'h00;
    endtask

    task automatic add_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
    endtask

    task automatic add_word(input logic [AW-1:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            stream.push_back(w[8*i +: 8]);
            csum ^= w[8*i +: 8];
        end
        exp_w.push_back({a, w});
    endtask

    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(csum);
`endif
    endtask

    task automatic send_stream();
        @(posedge clk); #1;
        foreach (stream[i]) begin
            rx_valid = 1'b1;
            rx_data  = stream[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        stream.delete();
    endtask

    task automatic expect_release(input string name);
        for (int i = 0; i < 100 && (core_rst || exp_tx.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release core_rst=%b err=%b busy=%b tx_valid=%b expected 0 0 0 0",
                     name, core_rst, err, busy, tx_valid);
        end
        n_checks++;
        if (exp_w.size() != 0 || exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending writes=%0d tx=%0d expected 0 0", name, exp_w.size(), exp_tx.size());
        end
    endtask

    task automatic expect_error(input string name);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || core_rst !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_error err=%b core_rst=%b tx_valid=%b busy=%b expected 1 1 0 0",
                     name, err, core_rst, tx_valid, busy);
        end
        n_checks++;
        if (exp_w.size() != 0 || exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending writes=%0d tx=%0d expected 0 0", name, exp_w.size(), exp_tx.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, core_rst, tx_valid, tx_data, busy, err} !==
            {1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values we=%b addr=%h wdata=%h core_rst=%b tx_valid=%b tx_data=%h busy=%b err=%b",
                     imem_we, imem_addr, imem_wdata, core_rst, tx_valid, tx_data, busy, err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        add_hdr(32'd2);
        add_word(0, 32'h12345678);
        add_word(1, 32'hDEADBEEF);
        add_csum();
        exp_tx.push_back(8'h06);
        fork
            send_stream();
            begin
                repeat (3) @(negedge clk);
                n_checks++;
                if (busy !== 1'b1 || core_rst !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_busy busy=%b core_rst=%b expected 1 1", busy, core_rst);
                end
            end
        join
        expect_release("basic");
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream();
        repeat (5) @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ignores_rx core_rst=%b busy=%b expected 0 0", core_rst, busy);
        end
    endtask

    task automatic test_zero();
        do_reset();
        add_hdr(32'd0);
        add_csum();
        exp_tx.push_back(8'h06);
        send_stream();
        expect_release("zero");
    endtask

    task automatic test_full_depth();
        do_reset();
        add_hdr(DEP);
        for (int i = 0; i < DEP; i++) add_word(AW'(i), $urandom());
        add_csum();
        exp_tx.push_back(8'h06);
        send_stream();
        expect_release("full_depth");
    endtask

    task automatic test_oversize();
        do_reset();
        add_hdr(DEP + 1);
        for (int i = 0; i < 8; i++) stream.push_back(8'(i * 17));
        exp_tx.push_back(8'h15);
        send_stream();
        expect_error("oversize");
    endtask

    task automatic test_timeout();
        int cyc;
        logic bad;
        do_reset();
        tx_ready = 1'b0;
        add_hdr(32'd1);
        stream.push_back(8'hAA);
        exp_tx.push_back(8'h15);
        send_stream();
        cyc = 0;
        while (err !== 1'b1 && cyc < 3 * TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != TMO) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d cycles expected %0d", cyc, TMO);
        end
        @(negedge clk);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h15) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL tx_hold tx_valid=%b tx_data=%h expected 1 15", tx_valid, tx_data);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        expect_error("timeout");
    endtask

    task automatic test_rst_mid();
        do_reset();
        add_hdr(32'd2);
        add_word(0, 32'hCAFEF00D);
        stream.push_back(8'h99);
        send_stream();
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || exp_w.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid core_rst=%b busy=%b pending=%0d expected 1 0 0", core_rst, busy, exp_w.size());
        end
        add_hdr(32'd1);
        add_word(0, 32'h11223344);
        add_csum();
        exp_tx.push_back(8'h06);
        send_stream();
        expect_release("rst_mid");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        add_hdr(32'd1);
        add_word(0, 32'h08040201);
        stream.push_back(8'h0F);
        exp_tx.push_back(8'h06);
        send_stream();
        expect_release("csum_ok");
        do_reset();
        add_hdr(32'd1);
        add_word(0, 32'h08040201);
        stream.push_back(8'h0E);
        exp_tx.push_back(8'h15);
        send_stream();
        expect_error("csum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_full_depth();
        test_oversize();
        test_timeout();
        test_rst_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
